// File: rtl/awg_dds_core.sv
// Dual-channel arithmetic DDS core: phase accumulator, triangle/saw/square/DC
// waveform, 1/16-step gain and a phase-offset B channel, with handshaked config.
module awg_dds_core #(
    parameter int ACC_W = 24,
    parameter int DAC_W = 14,
    parameter int PH_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [ACC_W-1:0] cfg_freq,
    input  logic [4:0]       cfg_amp,
    input  logic [PH_W-1:0]  cfg_phase,
    input  logic [1:0]       cfg_mode,
    output logic             sync,
    output logic [DAC_W-1:0] DA_A,
    output logic [DAC_W-1:0] DA_B
);

    localparam logic [DAC_W-1:0] MID     = {1'b1, {(DAC_W-1){1'b0}}};
    localparam logic [4:0]       AMP_MAX = 5'd16;

    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W:0]   acc_sum;
    logic             wrap;
    logic             take;
    logic             apply;
    logic [4:0]       amp_sat;

    logic [ACC_W-1:0] freq_act_reg;
    logic [4:0]       amp_act_reg;
    logic [PH_W-1:0]  phase_act_reg;
    logic [1:0]       mode_act_reg;

    logic             pend_valid_reg;
    logic [ACC_W-1:0] pend_freq_reg;
    logic [4:0]       pend_amp_reg;
    logic [PH_W-1:0]  pend_phase_reg;
    logic [1:0]       pend_mode_reg;

    logic             s1_valid_reg;
    logic             s1_zero_reg;
    logic [4:0]       s1_amp_reg;
    logic             sync_reg;

    logic [1:0][DAC_W-1:0] ch_u;
    logic [1:0][DAC_W-1:0] ch_da;

    assign acc_sum   = {1'b0, acc_reg} + {1'b0, freq_act_reg};
    assign wrap      = acc_sum[ACC_W];
    assign acc_next  = en ? acc_sum[ACC_W-1:0] : '0;
    assign cfg_ready = ~pend_valid_reg;
    assign take      = cfg_valid & ~pend_valid_reg;
    // Switching only at a wrap (or when idle/stopped) keeps each period on one config.
    assign apply     = pend_valid_reg & (~en | (freq_act_reg == '0) | wrap);
    assign amp_sat   = (cfg_amp > AMP_MAX) ? AMP_MAX : cfg_amp;

    // The phase offset only touches the top PH_W bits, so adding it to the
    // top DAC_W accumulator bits is exact (requires PH_W < DAC_W).
    assign ch_u[0] = acc_reg[ACC_W-1 -: DAC_W];
    assign ch_u[1] = acc_reg[ACC_W-1 -: DAC_W] + {phase_act_reg, {(DAC_W-PH_W){1'b0}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg        <= '0;
            freq_act_reg   <= '0;
            amp_act_reg    <= AMP_MAX;
            phase_act_reg  <= '0;
            mode_act_reg   <= 2'd0;
            pend_valid_reg <= 1'b0;
            pend_freq_reg  <= '0;
            pend_amp_reg   <= '0;
            pend_phase_reg <= '0;
            pend_mode_reg  <= 2'd0;
        end else begin
            acc_reg <= acc_next;
            if (take) begin
                pend_valid_reg <= 1'b1;
                pend_freq_reg  <= cfg_freq;
                pend_amp_reg   <= amp_sat;
                pend_phase_reg <= cfg_phase;
                pend_mode_reg  <= cfg_mode;
            end else if (apply) begin
                pend_valid_reg <= 1'b0;
                freq_act_reg   <= pend_freq_reg;
                amp_act_reg    <= pend_amp_reg;
                phase_act_reg  <= pend_phase_reg;
                mode_act_reg   <= pend_mode_reg;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_zero_reg  <= 1'b0;
            s1_amp_reg   <= '0;
            sync_reg     <= 1'b0;
        end else begin
            s1_valid_reg <= en;
            s1_zero_reg  <= (acc_reg == '0);
            s1_amp_reg   <= amp_act_reg;
            sync_reg     <= en & s1_valid_reg & s1_zero_reg;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        logic [DAC_W-1:0] tri_w;
        logic [DAC_W-1:0] wave_next;
        logic [DAC_W-1:0] wave_reg;
        logic [DAC_W-1:0] gain_out;
        logic [DAC_W-1:0] da_reg;
        logic [DAC_W:0]   s;
        logic [DAC_W+4:0] s_ext;
        logic [DAC_W+4:0] amp_ext;
        logic [DAC_W+4:0] prod;
        logic             gain_unused;

        assign tri_w = ch_u[gi][DAC_W-1] ? ~{ch_u[gi][DAC_W-2:0], 1'b0}
                                         :  {ch_u[gi][DAC_W-2:0], 1'b0};

        always_comb begin
            wave_next = MID;
            case (mode_act_reg)
                2'd0:    wave_next = tri_w;
                2'd1:    wave_next = ch_u[gi];
                2'd2:    wave_next = {DAC_W{ch_u[gi][DAC_W-1]}};
                default: wave_next = MID;
            endcase
        end

        // Two's-complement product: dropping the low 4 bits is a floor >>> 4.
        assign s           = {1'b0, wave_reg} - {1'b0, MID};
        assign s_ext       = {{4{s[DAC_W]}}, s};
        assign amp_ext     = {{DAC_W{1'b0}}, s1_amp_reg};
        assign prod        = s_ext * amp_ext;
        assign gain_out    = MID + prod[DAC_W+3:4];
        assign gain_unused = ^{prod[3:0], prod[DAC_W+4]};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wave_reg <= '0;
                da_reg   <= '0;
            end else begin
                wave_reg <= wave_next;
                da_reg   <= (en && s1_valid_reg) ? gain_out : '0;
            end
        end

        assign ch_da[gi] = da_reg;
    end

    assign DA_A = ch_da[0];
    assign DA_B = ch_da[1];
    assign sync = sync_reg;

endmodule

// File: tb/tb_awg_dds_core.sv
// Self-checking bench for awg_dds_core: constant vectors, directed corner
// sequences and randomized traffic against a cycle-level reference model.
module tb_awg_dds_core;
    localparam int ACC_W   = 24;
    localparam int DAC_W   = 14;
    localparam int PH_W    = 8;
    localparam int ACC_MOD = 1 << ACC_W;
    localparam int MID     = 8192;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [23:0] cfg_freq;
    logic [4:0]  cfg_amp;
    logic [7:0]  cfg_phase;
    logic [1:0]  cfg_mode;
    logic        sync;
    logic [13:0] DA_A;
    logic [13:0] DA_B;

    awg_dds_core #(.ACC_W(ACC_W), .DAC_W(DAC_W), .PH_W(PH_W)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_freq(cfg_freq), .cfg_amp(cfg_amp), .cfg_phase(cfg_phase), .cfg_mode(cfg_mode),
        .sync(sync), .DA_A(DA_A), .DA_B(DA_B)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc_n, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_acc, m_freq, m_amp, m_phase, m_mode;
    bit m_pend, m_took;
    int p_freq, p_amp, p_phase, p_mode;
    bit h_en;
    int h_acc, h_amp, h_phase, h_mode;
    int e_a, e_b, e_sync, e_ready;

    function automatic int wave_of(input int ph, input int mode);
        int u;
        u = ph / (1 << (ACC_W - DAC_W));
        case (mode)
            0:       return (u < MID) ? 2 * u : 32767 - 2 * u;
            1:       return u;
            2:       return (u >= MID) ? 16383 : 0;
            default: return MID;
        endcase
    endfunction

    function automatic int gain_of(input int w, input int amp);
        int p;
        p = (w - MID) * amp;
        if (p >= 0) return MID + p / 16;
        return MID - ((-p + 15) / 16);
    endfunction

    task automatic model_reset();
        m_acc = 0; m_freq = 0; m_amp = 16; m_phase = 0; m_mode = 0;
        m_pend = 0; m_took = 0;
        h_en = 0; h_acc = 0; h_amp = 16; h_phase = 0; h_mode = 0;
        e_a = 0; e_b = 0; e_sync = 0; e_ready = 1;
    endtask

    // Predicts the outputs visible after the coming rising edge.
    task automatic model_edge();
        int nxt;
        m_took = 0;
        if (en && h_en) begin
            e_a    = gain_of(wave_of(h_acc, h_mode), h_amp);
            e_b    = gain_of(wave_of((h_acc + h_phase * (1 << (ACC_W - PH_W))) % ACC_MOD, h_mode), h_amp);
            e_sync = (h_acc == 0);
        end else begin
            e_a = 0; e_b = 0; e_sync = 0;
        end
        h_en = en; h_acc = m_acc; h_amp = m_amp; h_phase = m_phase; h_mode = m_mode;
        nxt = en ? (m_acc + m_freq) % ACC_MOD : 0;
        if (!m_pend) begin
            if (cfg_valid) begin
                m_pend = 1; m_took = 1;
                p_freq = cfg_freq; p_amp = (cfg_amp > 16) ? 16 : cfg_amp;
                p_phase = cfg_phase; p_mode = cfg_mode;
            end
        end else if (!en || m_freq == 0 || (m_acc + m_freq) >= ACC_MOD) begin
            m_pend = 0;
            m_freq = p_freq; m_amp = p_amp; m_phase = p_phase; m_mode = p_mode;
        end
        m_acc = nxt;
        e_ready = !m_pend;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        cyc_n++;
        check("da_a", DA_A, e_a);
        check("da_b", DA_B, e_b);
        check("sync", sync, e_sync);
        check("cfg_ready", cfg_ready, e_ready);
    endtask

    task automatic send_cfg(input int freq, input int amp, input int phase, input int mode,
                            input int budget, output int waited);
        cfg_valid = 1; cfg_freq = freq[23:0]; cfg_amp = amp[4:0];
        cfg_phase = phase[7:0]; cfg_mode = mode[1:0];
        waited = 0;
        while (!cfg_ready && waited < budget) begin
            cycle();
            waited++;
        end
        check("cfg_wait_bound", int'(waited < budget), 1);
        cycle();
        check("cfg_take", int'(m_took), 1);
        cfg_valid = 0;
    endtask

    typedef struct {
        int freq; int amp; int phase; int mode;
        int a0; int b0; int a1; int b1;
    } vec_t;
    vec_t vt[8];

    int w, w2, n, max_a, min_a;
    int sq[$];

    initial begin
        vt[0] = '{24'h400000, 16, 8'h00, 0,    0,    0, 8192,  8192};
        vt[1] = '{24'h400000, 16, 8'h40, 0,    0, 8192, 8192, 16383};
        vt[2] = '{24'h800000,  8, 8'h80, 1, 4096, 8192, 8192,  4096};
        vt[3] = '{24'h800000, 20, 8'h00, 2,    0,    0, 16383, 16383};
        vt[4] = '{24'h123456,  5, 8'h33, 3, 8192, 8192, 8192,  8192};
        vt[5] = '{24'h7FFC00,  0, 8'h00, 1, 8192, 8192, 8192,  8192};
        vt[6] = '{24'h7FFC00, 16, 8'h00, 0,    0,    0, 16382, 16382};
        vt[7] = '{24'hFFFFFF,  3, 8'h01, 1, 6656, 6668, 9727,  6667};

        rst = 1; en = 0; cfg_valid = 0;
        cfg_freq = 0; cfg_amp = 0; cfg_phase = 0; cfg_mode = 0;
        model_reset();
        #12;
        check("rst_da_a", DA_A, 0);
        check("rst_da_b", DA_B, 0);
        check("rst_sync", sync, 0);
        check("rst_ready", cfg_ready, 1);
        @(negedge clk);
        rst = 0;

        // Constant vectors: config applied while stopped, then samples of acc=0 and acc=freq.
        for (int i = 0; i < 8; i++) begin
            en = 0;
            send_cfg(vt[i].freq, vt[i].amp, vt[i].phase, vt[i].mode, 20, w);
            cycle();
            en = 1;
            cycle();
            cycle();
            check($sformatf("vec%0d_a0", i), DA_A, vt[i].a0);
            check($sformatf("vec%0d_b0", i), DA_B, vt[i].b0);
            check($sformatf("vec%0d_sync0", i), sync, 1);
            cycle();
            check($sformatf("vec%0d_a1", i), DA_A, vt[i].a1);
            check($sformatf("vec%0d_b1", i), DA_B, vt[i].b1);
            check($sformatf("vec%0d_sync1", i), sync, 0);
            en = 0;
            cycle();
        end

        // Triangle at freq 2^10: full range and sync every 16384 clocks.
        send_cfg(1024, 16, 0, 0, 20, w);
        cycle();
        en = 1;
        max_a = 0; min_a = 99999;
        for (int i = 0; i < 2 * 16384 + 4; i++) begin
            cycle();
            if (sync) sq.push_back(cyc_n);
            if (i >= 2) begin
                if (DA_A > max_a) max_a = DA_A;
                if (DA_A < min_a) min_a = DA_A;
            end
        end
        check("tri_sync_count", sq.size(), 3);
        if (sq.size() >= 3) begin
            check("tri_sync_gap0", sq[1] - sq[0], 16384);
            check("tri_sync_gap1", sq[2] - sq[1], 16384);
        end
        check("tri_max", max_a, 16383);
        check("tri_min", min_a, 0);

        // Mid-period reconfig, second word stalls until the first is applied.
        for (int i = 0; i < 3000; i++) cycle();
        send_cfg(2048, 16, 8'h40, 0, 20, w);
        check("ready_drop", cfg_ready, 0);
        send_cfg(2048, 8, 0, 1, 40000, w2);
        check("cfg2_stalled", int'(w2 > 100), 1);
        n = 0;
        while (!e_ready && n < 20000) begin
            cycle();
            n++;
        end
        check("apply_wait_bound", int'(n < 20000), 1);
        cycle();
        cycle();
        max_a = 0; min_a = 99999;
        for (int i = 0; i < 8192; i++) begin
            cycle();
            if (DA_A > max_a) max_a = DA_A;
            if (DA_A < min_a) min_a = DA_A;
        end
        check("saw8_max", max_a, 12287);
        check("saw8_min", min_a, 4096);

        // en low for 5 clocks with a pending config; restart from phase 0.
        send_cfg(4096, 12, 3, 2, 20, w);
        en = 0;
        cycle();
        check("enlow_da_a", DA_A, 0);
        check("enlow_sync", sync, 0);
        cycle();
        check("enlow_ready", cfg_ready, 1);
        for (int i = 0; i < 3; i++) cycle();
        en = 1;
        cycle();
        cycle();
        check("restart_sync", sync, 1);
        for (int i = 0; i < 10; i++) cycle();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 19) != 0);
            if (cfg_valid && m_took) cfg_valid = 0;
            if (!cfg_valid && $urandom_range(0, 29) == 0) begin
                cfg_valid = 1;
                case ($urandom_range(0, 3))
                    0:       cfg_freq = 24'h0;
                    1:       cfg_freq = 24'($urandom_range(1, 4095));
                    default: cfg_freq = 24'($urandom_range(24'h100000, 24'hFFFFFF));
                endcase
                cfg_amp   = 5'($urandom_range(0, 31));
                cfg_phase = 8'($urandom);
                cfg_mode  = 2'($urandom_range(0, 3));
            end
            cycle();
        end
        cfg_valid = 0;

        // Asynchronous reset while a config is pending.
        en = 1;
        send_cfg(24'h200000, 16, 0, 1, 40, w);
        send_cfg(24'h000100, 16, 0, 0, 40, w);
        rst = 1;
        #1;
        check("arst_da_a", DA_A, 0);
        check("arst_da_b", DA_B, 0);
        check("arst_sync", sync, 0);
        check("arst_ready", cfg_ready, 1);
        @(negedge clk);
        rst = 0;
        model_reset();
        for (int i = 0; i < 10; i++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
